interp_scaler: RTL
==================

INTERP_SCALER -- requirements
Module: interp_scaler

Interface
REQ-001 SHALL have parameter DW, default 8: pixel data width.
REQ-002 SHALL have parameter AW, default 6: address bits per axis; ADDR is {row,col}, 2*AW bits.
REQ-003 SHALL have parameter FB, default 4: fraction bits of scale step; window bound 2^FB source pixels per axis.
REQ-004 SHALL have parameter ON, default 17: output grid is ON x ON pixels.
REQ-005 SHALL have port clk  in  1  sole clock, all state rising-edge.
REQ-006 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port START  in  1  one-cycle pulse; latches H0,V0,SW,SH,MODE.
REQ-008 SHALL have ports H0 and V0  in  AW each  source window origin column and row.
REQ-009 SHALL have ports SW and SH  in  FB each  horizontal and vertical step, in units of 2^-FB source pixel.
REQ-010 SHALL have port MODE  in  1  0 = bilinear, 1 = nearest (floor).
REQ-011 SHALL have port REN  out  1  active-low memory read enable.
REQ-012 SHALL have port ADDR  out  2*AW  read address.
REQ-013 SHALL have port R_DATA  in  DW  read data, valid the cycle after the cycle REN=0.
REQ-014 SHALL have port O_DATA  out  DW  output pixel.
REQ-015 SHALL have port O_VALID  out  1  O_DATA valid.
REQ-016 SHALL have port O_READY  in  1  consumer accept; a pixel transfers when O_VALID and O_READY are both 1.
REQ-017 SHALL have port BUSY  out  1  high in every state except IDLE.

Function
REQ-018 SHALL implement states IDLE, LOAD, DRAIN, RUN: START to LOAD; last address issued to DRAIN; last datum captured to RUN; last pixel transferred to IDLE.
REQ-019 In LOAD, SHALL issue one address per cycle with REN=0, rows V0..V0+SH, columns H0..H0+SW, row-major, into a 2^FB x 2^FB buffer at (row-V0, col-H0).
REQ-020 Address components SHALL wrap modulo 2^AW: H0=62, SW=4 reads columns 62,63,0,1,2.
REQ-021 REN SHALL be 1 in all states except LOAD; ADDR SHALL hold its last value when REN=1.
REQ-022 Output pixel (i,j), i,j in 0..ON-1, raster order j-major: p=SW*i, q=SH*j (2*FB bits); a=p>>FB, x=p mod 2^FB, b=q>>FB, y=q mod 2^FB.
REQ-023 Bilinear: vertical blend per column, t=(P[b][c]*(2^FB-y)+P[b+1][c]*y)>>FB, then horizontal with x using the same form; fraction 0 SHALL use the single sample and never access index+1.
REQ-024 Nearest: O_DATA=P[b][a].
REQ-025 Intermediate products SHALL be DW+FB+1 bits wide; results truncate to DW without overflow.
REQ-026 O_VALID/O_DATA SHALL remain stable while O_READY=0; no pixel SHALL be dropped or duplicated; exactly ON*ON transfers per START.
REQ-027 First O_VALID SHALL assert the cycle after entering RUN; with O_READY held 1, one pixel per cycle.
REQ-028 SW=0 or SH=0 SHALL load a single column or row and replicate it.
REQ-029 START in any non-IDLE state SHALL abort, discard the buffer, relatch inputs and enter LOAD next cycle; O_VALID SHALL be 0 that cycle.

Reset
REQ-030 On RST=1 at a clock edge: state IDLE, REN=1, ADDR=0, O_DATA=0, O_VALID=0, BUSY=0, counters 0; buffer contents need not clear.
REQ-031 RST SHALL override START in the same cycle; reset mid-LOAD or mid-RUN discards all progress.

Configuration
REQ-032 Macro INTERP_SCALER_ROUND_EN defined: each blend stage SHALL add 2^(FB-1) before >>FB; undefined: pure truncation.

Verification
REQ-033 SW=SH=0, memory all 100, O_READY=1 -> 289 pixels, all 100, then BUSY=0.
REQ-034 Pixel=16*col, H0=V0=0, SW=SH=8, bilinear -> each row outputs 8*i, i=0..16 (0..128).
REQ-035 O_READY low 5 cycles at pixel 40 -> O_DATA held 5 cycles, total 289 transfers, sequence unchanged.
REQ-036 H0=62, V0=63, SW=SH=4 -> ADDR columns 62,63,0,1,2, rows 63,0,1,2,3, 25 reads.
REQ-037 Pixels P[0][0]=0, P[0][1]=1, SW=8, SH=0, i=1 -> O_DATA 0 without macro, 1 with INTERP_SCALER_ROUND_EN; MODE=1 -> 0 both.
REQ-038 START reasserted mid-RUN, then RST mid-LOAD -> immediate relatch to LOAD, then IDLE with all outputs at reset values next cycle.

Source files
------------

// File: rtl/interp_scaler.sv
// ----------------------------------------------------------------------------
// interp_scaler
//
// Loads a (SH+1) x (SW+1) window of source pixels from a synchronous read
// memory into a 2^FB x 2^FB local buffer. It then produces an ON x ON output
// grid. Each output pixel is either bilinear-interpolated or a nearest (floor)
// sample of the window. The step between output pixels is SW/SH in units of
// 2^-FB source pixel.
//
// Optional feature: define INTERP_SCALER_ROUND_EN to add 2^(FB-1) before each
// >>FB blend stage (round half up). Otherwise each stage truncates.
//
// Ports
//   clk      in   sole clock, rising edge
//   RST      in   synchronous active-high reset
//   START    in   one-cycle pulse; latches H0/V0/SW/SH/MODE, aborts any job
//   H0, V0   in   window origin column / row (AW bits, wrap modulo 2^AW)
//   SW, SH   in   horizontal / vertical step (FB fraction bits)
//   MODE     in   0 = bilinear, 1 = nearest
//   REN      out  active-low read enable (low only while loading)
//   ADDR     out  read address {row, col}; holds while REN=1
//   R_DATA   in   read data, valid the cycle after REN=0
//   O_DATA   out  output pixel
//   O_VALID  out  O_DATA valid; held stable until O_READY
//   O_READY  in   consumer accept
//   BUSY     out  high whenever not idle
// ----------------------------------------------------------------------------
module interp_scaler #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 6,
    parameter int unsigned FB = 4,
    parameter int unsigned ON = 17
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            START,
    input  logic [AW-1:0]   H0,
    input  logic [AW-1:0]   V0,
    input  logic [FB-1:0]   SW,
    input  logic [FB-1:0]   SH,
    input  logic            MODE,
    output logic            REN,
    output logic [2*AW-1:0] ADDR,
    input  logic [DW-1:0]   R_DATA,
    output logic [DW-1:0]   O_DATA,
    output logic            O_VALID,
    input  logic            O_READY,
    output logic            BUSY
);

    localparam int unsigned CW    = (ON > 1) ? $clog2(ON) : 1;
    localparam int unsigned PW    = DW + FB + 1;
    localparam int unsigned BN    = 1 << (2 * FB);
    localparam int unsigned OneFb = 1 << FB;

    localparam logic [FB-1:0] FbOne   = FB'(1);
    localparam logic [CW-1:0] CwOne   = CW'(1);
    localparam logic [CW-1:0] LastIdx = CW'(ON - 1);

`ifdef INTERP_SCALER_ROUND_EN
    localparam logic [PW-1:0] RndAdd = PW'(1 << (FB - 1));
`else
    localparam logic [PW-1:0] RndAdd = '0;
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StRun} state_e;

    state_e            r_state;
    logic              r_ren;
    logic [2*AW-1:0]   r_addr;
    logic [DW-1:0]     r_o_data;
    logic              r_o_valid;
    logic              r_busy;

    logic [AW-1:0]     r_h0;
    logic [AW-1:0]     r_v0;
    logic [FB-1:0]     r_sw;
    logic [FB-1:0]     r_sh;
    logic              r_mode;

    // Window position of the address currently on ADDR.
    logic [FB-1:0]     r_ld_r;
    logic [FB-1:0]     r_ld_c;
    // Position of the read issued last cycle, whose data is on R_DATA now.
    logic              r_cap_valid;
    logic [FB-1:0]     r_cap_r;
    logic [FB-1:0]     r_cap_c;

    // Next output pixel to compute: column i, row j.
    logic [CW-1:0]     r_pi;
    logic [CW-1:0]     r_pj;
    logic              r_prod_done;

    logic [DW-1:0]     r_buf [BN];

    // ---------------------------------------------------------------- load
    logic              w_ld_last_c;
    logic              w_ld_last;
    logic [FB-1:0]     w_nx_r;
    logic [FB-1:0]     w_nx_c;
    logic [2*AW-1:0]   w_nx_addr;

    assign w_ld_last_c = (r_ld_c == r_sw);
    assign w_ld_last   = w_ld_last_c && (r_ld_r == r_sh);
    assign w_nx_c      = w_ld_last_c ? '0 : r_ld_c + FbOne;
    assign w_nx_r      = w_ld_last_c ? r_ld_r + FbOne : r_ld_r;
    assign w_nx_addr   = {r_v0 + AW'(w_nx_r), r_h0 + AW'(w_nx_c)};

    // ----------------------------------------------------------- interpolate
    function automatic logic [DW-1:0] blend(input logic [DW-1:0] s0,
                                            input logic [DW-1:0] s1,
                                            input logic [FB-1:0] f);
        logic [PW-1:0] acc;
        acc = PW'(s0) * (PW'(OneFb) - PW'(f)) + PW'(s1) * PW'(f) + RndAdd;
        return DW'(acc >> FB);
    endfunction

    logic [2*FB-1:0]   w_p;
    logic [2*FB-1:0]   w_q;
    logic [FB-1:0]     w_a;
    logic [FB-1:0]     w_x;
    logic [FB-1:0]     w_b;
    logic [FB-1:0]     w_y;
    logic [FB-1:0]     w_a1;
    logic [FB-1:0]     w_b1;
    logic [DW-1:0]     w_s00;
    logic [DW-1:0]     w_s01;
    logic [DW-1:0]     w_s10;
    logic [DW-1:0]     w_s11;
    logic [DW-1:0]     w_v0;
    logic [DW-1:0]     w_v1;
    logic [DW-1:0]     w_pix;
    logic              w_pix_last;

    assign w_p = (2*FB)'(r_sw) * (2*FB)'(r_pi);
    assign w_q = (2*FB)'(r_sh) * (2*FB)'(r_pj);
    assign w_a = w_p[2*FB-1:FB];
    assign w_x = w_p[FB-1:0];
    assign w_b = w_q[2*FB-1:FB];
    assign w_y = w_q[FB-1:0];

    // A zero fraction stays on the base sample so index+1 is never touched;
    // with a nonzero fraction index+1 is always inside the loaded window.
    assign w_a1 = (w_x != '0) ? w_a + FbOne : w_a;
    assign w_b1 = (w_y != '0) ? w_b + FbOne : w_b;

    assign w_s00 = r_buf[{w_b,  w_a }];
    assign w_s01 = r_buf[{w_b,  w_a1}];
    assign w_s10 = r_buf[{w_b1, w_a }];
    assign w_s11 = r_buf[{w_b1, w_a1}];

    assign w_v0  = blend(w_s00, w_s10, w_y);
    assign w_v1  = blend(w_s01, w_s11, w_y);
    assign w_pix = r_mode ? w_s00 : blend(w_v0, w_v1, w_x);

    assign w_pix_last = (r_pi == LastIdx) && (r_pj == LastIdx);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state     <= StIdle;
            r_ren       <= 1'b1;
            r_addr      <= '0;
            r_o_data    <= '0;
            r_o_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_h0        <= '0;
            r_v0        <= '0;
            r_sw        <= '0;
            r_sh        <= '0;
            r_mode      <= 1'b0;
            r_ld_r      <= '0;
            r_ld_c      <= '0;
            r_cap_valid <= 1'b0;
            r_cap_r     <= '0;
            r_cap_c     <= '0;
            r_pi        <= '0;
            r_pj        <= '0;
            r_prod_done <= 1'b0;
        end else if (START) begin
            // Start or abort: relatch and restart the load from the origin.
            r_state     <= StLoad;
            r_h0        <= H0;
            r_v0        <= V0;
            r_sw        <= SW;
            r_sh        <= SH;
            r_mode      <= MODE;
            r_ren       <= 1'b0;
            r_addr      <= {V0, H0};
            r_ld_r      <= '0;
            r_ld_c      <= '0;
            r_cap_valid <= 1'b0;
            r_o_valid   <= 1'b0;
            r_busy      <= 1'b1;
            r_pi        <= '0;
            r_pj        <= '0;
            r_prod_done <= 1'b0;
        end else begin
            r_cap_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                end
                StLoad: begin
                    r_cap_valid <= 1'b1;
                    r_cap_r     <= r_ld_r;
                    r_cap_c     <= r_ld_c;
                    if (w_ld_last) begin
                        r_state <= StDrain;
                        r_ren   <= 1'b1;
                    end else begin
                        r_ld_r  <= w_nx_r;
                        r_ld_c  <= w_nx_c;
                        r_addr  <= w_nx_addr;
                    end
                end
                StDrain: begin
                    // Last datum is written this cycle.
                    r_state <= StRun;
                end
                StRun: begin
                    if (!r_o_valid || O_READY) begin
                        if (r_prod_done) begin
                            r_state   <= StIdle;
                            r_o_valid <= 1'b0;
                            r_busy    <= 1'b0;
                        end else begin
                            r_o_data  <= w_pix;
                            r_o_valid <= 1'b1;
                            if (w_pix_last) begin
                                r_prod_done <= 1'b1;
                            end else if (r_pi == LastIdx) begin
                                r_pi <= '0;
                                r_pj <= r_pj + CwOne;
                            end else begin
                                r_pi <= r_pi + CwOne;
                            end
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Window buffer; contents are not reset.
    always_ff @(posedge clk) begin
        if (!RST && !START && r_cap_valid) begin
            r_buf[{r_cap_r, r_cap_c}] <= R_DATA;
        end
    end

    assign REN     = r_ren;
    assign ADDR    = r_addr;
    assign O_DATA  = r_o_data;
    assign O_VALID = r_o_valid;
    assign BUSY    = r_busy;

endmodule
